hit_frame_serializer: RTL and testbench

- Upstream producer for the hit-RAM dump stage.
- Counts single-cycle hit pulses on NCH channels in one SYSCLK-domain counter bank.
- On each trigger, snapshots and clears all counters, pulses dumpMem, then streams a fixed-length byte frame (header word, counters, zero padding) on an 8-bit data channel with a write enable.
- Waits for the downstream dumpdone before accepting the next trigger. Triggers that arrive while busy are dropped and counted, so hit windows stay contiguous.

---
 rtl/tdc_frame_pkg.sv | 26 ++
 rtl/hit_frame_serializer_if.sv | 23 ++
 rtl/hit_counter_bank.sv | 50 +++++
 rtl/hit_frame_serializer.sv | 146 ++++++++++++++
 tb/tb_hit_frame_serializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_frame_pkg.sv
// Shared types and constants for the hit-frame serializer slice.
package tdc_frame_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_FRAME_WORDS = 256;
  localparam logic [7:0]  DEF_HDR_TAG     = 8'hA5;

  // Byte b of a frame word, most significant byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/hit_frame_serializer_if.sv
// Frame data channel between the serializer and the hit-RAM dump stage.
interface hit_frame_serializer_if;

  logic       dumpMem;
  logic       write_En_datachannel;
  logic [7:0] data_datachannel;
  logic       dumpdone;

  modport master (
    output dumpMem,
    output write_En_datachannel,
    output data_datachannel,
    input  dumpdone
  );

  modport slave (
    input  dumpMem,
    input  write_En_datachannel,
    input  data_datachannel,
    output dumpdone
  );

endinterface

// File: rtl/hit_counter_bank.sv
// Per-channel saturating hit counters with a snapshot array read by word index.
module hit_counter_bank
  import tdc_frame_pkg::*;
#(
  parameter int unsigned NCH   = 64,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              SYSCLK,
  input  logic              reset,
  input  logic [NCH-1:0]    hits_i,
  input  logic              snap_i,
  input  logic [CH_W-1:0]   sel_i,
  output logic [WORD_W-1:0] snap_word_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] snap_q [NCH];

  // Count hits; on snapshot the trigger-cycle hit goes into the snapshot
  // and the live counter restarts from zero, so each hit lands in exactly one window.
  always_ff @(posedge SYSCLK) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (snap_i) begin
          snap_q[i] <= (hits_i[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
          cnt_q[i]  <= '0;
        end else if (hits_i[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Zero-extended snapshot of the selected channel; out-of-range selects read zero.
  always_comb begin
    snap_word_c = '0;
    if (32'(sel_i) < NCH) begin
      snap_word_c = WORD_W'(snap_q[sel_i]);
    end
  end

endmodule

// File: rtl/hit_frame_serializer.sv
// Hit-count frame producer: snapshot on trigger, then stream header, counters, padding.
module hit_frame_serializer
  import tdc_frame_pkg::*;
#(
  parameter int unsigned NCH         = 64,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned BYTE_GAP    = 1,
  parameter logic [7:0]  HDR_TAG     = DEF_HDR_TAG
) (
  input  logic                 SYSCLK,
  input  logic                 reset,
  input  logic [NCH-1:0]       hits,
  input  logic                 trigger,
  output logic                 busy,
  output logic [23:0]          frame_number,
  output logic [15:0]          dropped_triggers,
  hit_frame_serializer_if.master dch
);

  localparam int unsigned TOTAL_BYTES = FRAME_WORDS * BYTES_PER_WORD;
  localparam int unsigned BIDX_W      = $clog2(TOTAL_BYTES);
  localparam int unsigned WIDX_W      = BIDX_W - 2;
  localparam int unsigned CH_W        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned GAP_W       = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(BYTE_GAP - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(TOTAL_BYTES - 1);

  state_t              state_q;
  logic [BIDX_W-1:0]   byte_idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic                done_q;
  logic                dump_mem_q;
  logic                we_q;
  logic [7:0]          data_q;
  logic                busy_q;
  logic [23:0]         frame_q;
  logic [15:0]         drop_q;

  logic                accept_c;
  logic                emit_c;
  logic [WIDX_W-1:0]   word_idx_c;
  logic [CH_W-1:0]     ch_sel_c;
  logic [WORD_W-1:0]   bank_word_c;
  logic [WORD_W-1:0]   word_c;
  logic [7:0]          byte_c;

  assign accept_c   = (state_q == IDLE) && trigger;
  assign emit_c     = (state_q == ARM) || ((state_q == STREAM) && (gap_q == '0));
  assign word_idx_c = byte_idx_q[BIDX_W-1:2];
  assign ch_sel_c   = CH_W'(word_idx_c - WIDX_W'(1));

  hit_counter_bank #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) u_bank (
    .SYSCLK      (SYSCLK),
    .reset       (reset),
    .hits_i      (hits),
    .snap_i      (accept_c),
    .sel_i       (ch_sel_c),
    .snap_word_c (bank_word_c)
  );

  // Frame word mux: header, channel snapshots, then zero padding.
  always_comb begin
    word_c = '0;
    if (word_idx_c == '0) begin
      word_c = {HDR_TAG, frame_q};
    end else if (32'(word_idx_c) <= NCH) begin
      word_c = bank_word_c;
    end
  end

  assign byte_c = word_byte(word_c, byte_idx_q[1:0]);

  // Frame FSM with byte/gap sequencing, done latch and drop counter.
  always_ff @(posedge SYSCLK) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      dump_mem_q <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      frame_q    <= '0;
      drop_q     <= '0;
    end else begin
      dump_mem_q <= 1'b0;
      we_q       <= 1'b0;

      if (trigger && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end

      // An early dumpdone is remembered until WAIT_DONE consumes it.
      if (dch.dumpdone && (state_q != IDLE)) begin
        done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q    <= ARM;
            dump_mem_q <= 1'b1;
            busy_q     <= 1'b1;
            frame_q    <= frame_q + 24'd1;
            byte_idx_q <= '0;
            gap_q      <= '0;
          end
        end
        ARM, STREAM: begin
          if (emit_c) begin
            we_q       <= 1'b1;
            data_q     <= byte_c;
            byte_idx_q <= byte_idx_q + BIDX_W'(1);
            gap_q      <= GAP_RELOAD;
            state_q    <= (byte_idx_q == LAST_BYTE) ? WAIT_DONE : STREAM;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        WAIT_DONE: begin
          if (done_q || dch.dumpdone) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dch.dumpMem              = dump_mem_q;
  assign dch.write_En_datachannel = we_q;
  assign dch.data_datachannel     = data_q;
  assign busy                     = busy_q;
  assign frame_number             = frame_q;
  assign dropped_triggers         = drop_q;

endmodule

// File: tb/tb_hit_frame_serializer.sv
// Directed bench: DUT1 (CNT_W=16, gap 1) and DUT2 (CNT_W=4, gap 3), NCH=4, 8-word frames.
module tb_hit_frame_serializer;

  logic        SYSCLK = 1'b0;
  logic        rst1, rst2;
  logic [3:0]  hits1, hits2;
  logic        trig1, trig2;
  logic        busy1, busy2;
  logic [23:0] fn1, fn2;
  logic [15:0] dt1, dt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int te;

  logic [7:0] b1_q[$];
  logic [7:0] b2_q[$];
  int         s1_q[$];
  int         s2_q[$];
  int         dm1_n = 0;
  int         dm2_n = 0;

  hit_frame_serializer_if dch1();
  hit_frame_serializer_if dch2();

  hit_frame_serializer #(
    .NCH(4), .CNT_W(16), .FRAME_WORDS(8), .BYTE_GAP(1), .HDR_TAG(8'hA5)
  ) u_dut1 (
    .SYSCLK(SYSCLK), .reset(rst1), .hits(hits1), .trigger(trig1), .busy(busy1),
    .frame_number(fn1), .dropped_triggers(dt1), .dch(dch1)
  );

  hit_frame_serializer #(
    .NCH(4), .CNT_W(4), .FRAME_WORDS(8), .BYTE_GAP(3), .HDR_TAG(8'hA5)
  ) u_dut2 (
    .SYSCLK(SYSCLK), .reset(rst2), .hits(hits2), .trigger(trig2), .busy(busy2),
    .frame_number(fn2), .dropped_triggers(dt2), .dch(dch2)
  );

  always #5 SYSCLK = ~SYSCLK;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  // Byte/strobe-cycle recorder and dumpMem pulse counter for both DUTs.
  always @(negedge SYSCLK) begin
    if (dch1.write_En_datachannel === 1'b1) begin
      b1_q.push_back(dch1.data_datachannel);
      s1_q.push_back(cyc);
    end
    if (dch2.write_En_datachannel === 1'b1) begin
      b2_q.push_back(dch2.data_datachannel);
      s2_q.push_back(cyc);
    end
    if (dch1.dumpMem === 1'b1) dm1_n++;
    if (dch2.dumpMem === 1'b1) dm2_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  // Wait until DUT 'which' has produced n bytes in total, bounded by budget cycles.
  task automatic wait_bytes(input int which, input int n, input int budget);
    int k = 0;
    int sz;
    sz = (which == 1) ? b1_q.size() : b2_q.size();
    while (sz < n && k < budget) begin
      tick(1);
      k++;
      sz = (which == 1) ? b1_q.size() : b2_q.size();
    end
    chk($sformatf("bytes%0d", which), 32'(sz), 32'(n));
  endtask

  function automatic logic [7:0] fb(input int i, input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w2, input logic [31:0] w3,
                                    input logic [31:0] w4);
    logic [31:0] w;
    logic [31:0] sh;
    case (i / 4)
      0: w = w0;
      1: w = w1;
      2: w = w2;
      3: w = w3;
      4: w = w4;
      default: w = 32'h0;
    endcase
    sh = w >> (8 * (3 - (i % 4)));
    return sh[7:0];
  endfunction

  // Compare 32 frame bytes and their strobe cycles against words w0..w4 (rest zero).
  task automatic chk_frame(input int which, input int base, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                           input logic [31:0] w4, input int start, input int gap);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] ob;
      int         oc;
      ob = (which == 1) ? b1_q[base + i] : b2_q[base + i];
      oc = (which == 1) ? s1_q[base + i] : s2_q[base + i];
      chk($sformatf("d%0d_byte%0d", which, base + i), 32'(ob), 32'(fb(i, w0, w1, w2, w3, w4)));
      chk($sformatf("d%0d_cyc%0d", which, base + i), 32'(oc), 32'(start + i * gap));
    end
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    hits1 = '0; hits2 = '0;
    trig1 = 1'b0; trig2 = 1'b0;
    dch1.dumpdone = 1'b0; dch2.dumpdone = 1'b0;
    tick(3);

    // Reset values
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_fn1", 32'(fn1), 32'd0);
    chk("rst_dt1", 32'(dt1), 32'd0);
    chk("rst_dm1", 32'(dch1.dumpMem), 32'd0);
    chk("rst_we1", 32'(dch1.write_En_datachannel), 32'd0);
    chk("rst_data1", 32'(dch1.data_datachannel), 32'h00);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_fn2", 32'(fn2), 32'd0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick(1);

    // Frame 1 on DUT1: hits[0] x3, hits[2] x1, plus 3 triggers while streaming
    hits1 = 4'b0101; tick(1);
    hits1 = 4'b0001; tick(2);
    hits1 = 4'b0000; tick(1);
    trig1 = 1'b1; te = cyc + 1; tick(1); trig1 = 1'b0;
    chk("f1_dumpMem", 32'(dch1.dumpMem), 32'd1);
    chk("f1_busy", 32'(busy1), 32'd1);
    chk("f1_fn", 32'(fn1), 32'd1);
    chk("f1_we_arm", 32'(dch1.write_En_datachannel), 32'd0);
    tick(1);
    chk("f1_dumpMem_low", 32'(dch1.dumpMem), 32'd0);
    chk("f1_first_we", 32'(dch1.write_En_datachannel), 32'd1);
    tick(2);
    repeat (3) begin
      trig1 = 1'b1; tick(1);
      trig1 = 1'b0; tick(1);
    end
    wait_bytes(1, 32, 100);
    chk("f1_dm_count", 32'(dm1_n), 32'd1);
    chk("f1_dropped", 32'(dt1), 32'd3);
    chk("f1_fn_end", 32'(fn1), 32'd1);
    chk_frame(1, 0, 32'hA5000001, 32'h3, 32'h0, 32'h1, 32'h0, te + 1, 1);
    tick(5);
    chk("f1_wait_busy", 32'(busy1), 32'd1);
    dch1.dumpdone = 1'b1; tick(1); dch1.dumpdone = 1'b0;
    chk("f1_idle", 32'(busy1), 32'd0);

    // Frame 2: hits[3] in trigger cycle and the next one; early dumpdone in STREAM
    hits1 = 4'b1000; trig1 = 1'b1; te = cyc + 1; tick(1);
    trig1 = 1'b0; tick(1);
    hits1 = 4'b0000;
    tick(3);
    dch1.dumpdone = 1'b1; tick(1); dch1.dumpdone = 1'b0;
    wait_bytes(1, 64, 100);
    chk("f2_idle_after_last", 32'(busy1), 32'd0);
    chk("f2_we_off", 32'(dch1.write_En_datachannel), 32'd0);
    chk_frame(1, 32, 32'hA5000002, 32'h0, 32'h0, 32'h0, 32'h1, te + 1, 1);

    // Frame 3: accepted two cycles after the last strobe; carries the post-trigger hit
    trig1 = 1'b1; te = cyc + 1; tick(1); trig1 = 1'b0;
    chk("f3_dumpMem", 32'(dch1.dumpMem), 32'd1);
    chk("f3_fn", 32'(fn1), 32'd3);
    chk("f3_dropped", 32'(dt1), 32'd3);
    wait_bytes(1, 96, 100);
    chk("f3_dm_count", 32'(dm1_n), 32'd3);
    chk_frame(1, 64, 32'hA5000003, 32'h0, 32'h0, 32'h0, 32'h1, te + 1, 1);

    // Trigger on the IDLE-return edge counts as a drop
    dch1.dumpdone = 1'b1; trig1 = 1'b1; tick(1);
    dch1.dumpdone = 1'b0; trig1 = 1'b0;
    chk("ret_dropped", 32'(dt1), 32'd4);
    chk("ret_busy", 32'(busy1), 32'd0);
    tick(2);
    chk("ret_no_frame", 32'(dm1_n), 32'd3);
    chk("ret_fn", 32'(fn1), 32'd3);

    // DUT2 saturation: 20 hits on channel 1 with 4-bit counters
    hits2 = 4'b0010; tick(20);
    hits2 = 4'b0000; tick(1);
    trig2 = 1'b1; te = cyc + 1; tick(1); trig2 = 1'b0;
    chk("s_dumpMem", 32'(dch2.dumpMem), 32'd1);
    chk("s_fn", 32'(fn2), 32'd1);
    wait_bytes(2, 32, 200);
    chk_frame(2, 0, 32'hA5000001, 32'h0, 32'hF, 32'h0, 32'h0, te + 1, 3);
    dch2.dumpdone = 1'b1; tick(1); dch2.dumpdone = 1'b0;
    chk("s_idle", 32'(busy2), 32'd0);

    // DUT2 reset at byte 10 of the next frame, with hits pending in the counters
    trig2 = 1'b1; te = cyc + 1; tick(1); trig2 = 1'b0;
    hits2 = 4'b0001; tick(2); hits2 = 4'b0000;
    wait_bytes(2, 42, 100);
    chk("r_byte10_cyc", 32'(s2_q[41]), 32'(te + 28));
    rst2 = 1'b1; tick(1);
    chk("r_we", 32'(dch2.write_En_datachannel), 32'd0);
    chk("r_busy", 32'(busy2), 32'd0);
    chk("r_dumpMem", 32'(dch2.dumpMem), 32'd0);
    chk("r_fn", 32'(fn2), 32'd0);
    tick(4);
    rst2 = 1'b0; tick(1);
    chk("r_no_more_bytes", 32'(b2_q.size()), 32'd42);

    // Post-reset frame: header restarts at 1, channel 0 cleared, channel 2 one hit
    hits2 = 4'b0100; tick(1);
    hits2 = 4'b0000; tick(1);
    trig2 = 1'b1; te = cyc + 1; tick(1); trig2 = 1'b0;
    chk("p_fn", 32'(fn2), 32'd1);
    wait_bytes(2, 74, 200);
    chk_frame(2, 42, 32'hA5000001, 32'h0, 32'h0, 32'h1, 32'h0, te + 1, 3);
    dch2.dumpdone = 1'b1; tick(1); dch2.dumpdone = 1'b0;
    chk("p_idle", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
